// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-flop sync, shared sample tick, debounce, press/release pulses.
// Optional auto-repeat pulses are compiled in with `define KEY_DEBOUNCE_REPEAT_EN.

module key_debounce_lane #(
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic smp,     // normalised sample, 1 = pressed
  output logic lvl_o,
  output logic prs_o,
  output logic rel_o,
  output logic rpt_o
);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_SAMPLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       lvl_q, lvl_d;
  logic       prs_q, prs_d;
  logic       rel_q, rel_d;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    prs_d = 1'b0;
    rel_d = 1'b0;
    if (tick) begin
      if (smp == lvl_q) begin
        cnt_d = 8'd0;
      end else if (cnt_q == CNT_LAST) begin
        lvl_d = ~lvl_q;
        cnt_d = 8'd0;
        prs_d = ~lvl_q;
        rel_d = lvl_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      lvl_q <= 1'b0;
      prs_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      prs_q <= prs_d;
      rel_q <= rel_d;
    end
  end

  assign lvl_o = lvl_q;
  assign prs_o = prs_q;
  assign rel_o = rel_q;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam logic [15:0] DLY = 16'(REPEAT_DELAY);
  localparam logic [15:0] PER = 16'(REPEAT_PERIOD);

  logic [15:0] hold_q, hold_d;
  logic        per_q, per_d;   // 0: waiting for initial delay, 1: periodic phase
  logic        rpt_q, rpt_d;

  always_comb begin
    hold_d = hold_q;
    per_d  = per_q;
    rpt_d  = 1'b0;
    // A press or release accepted this tick restarts the hold timing and wins over repeat.
    if (prs_d || rel_d) begin
      hold_d = 16'd0;
      per_d  = 1'b0;
    end else if (tick && lvl_q) begin
      hold_d = hold_q + 16'd1;
      if (hold_d == (per_q ? PER : DLY)) begin
        rpt_d  = 1'b1;
        hold_d = 16'd0;
        per_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 16'd0;
      per_q  <= 1'b0;
      rpt_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      per_q  <= per_d;
      rpt_q  <= rpt_d;
    end
  end

  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif
endmodule

module key_debounce_multi #(
  parameter int   N_KEYS         = 3,
  parameter int   SAMPLE_DIV     = 50000,
  parameter int   STABLE_SAMPLES = 4,
  parameter logic PRESS_LEVEL    = 1'b1,
  parameter int   REPEAT_DELAY   = 500,
  parameter int   REPEAT_PERIOD  = 100
) (
  input  logic              Clk_50mhz,
  input  logic              Rst_n,
  input  logic [N_KEYS-1:0] btn_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              sample_tick
);
  localparam int            DW       = $clog2(SAMPLE_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  logic [DW-1:0]     div_q, div_d;
  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic [N_KEYS-1:0] smp;

  assign sample_tick = (div_q == DIV_LAST);

  always_comb begin
    div_d   = sample_tick ? '0 : div_q + 1'b1;
    sync1_d = btn_in;
    sync2_d = sync1_q;
  end

  // Synchronisers reset to the released level so reset exit never looks like a press.
  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      div_q   <= '0;
      sync1_q <= {N_KEYS{~PRESS_LEVEL}};
      sync2_q <= {N_KEYS{~PRESS_LEVEL}};
    end else begin
      div_q   <= div_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign smp = sync2_q ~^ {N_KEYS{PRESS_LEVEL}};

  for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_lane (
      .clk  (Clk_50mhz),
      .rst_n(Rst_n),
      .tick (sample_tick),
      .smp  (smp[i]),
      .lvl_o(key_level[i]),
      .prs_o(key_press[i]),
      .rel_o(key_release[i]),
      .rpt_o(key_repeat[i])
    );
  end
endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: active-high DUT plus an active-low DUT sharing clock/reset.
module tb_key_debounce_multi;
  logic       clk = 1'b0;
  logic       Rst_n;
  logic [2:0] btn, btn_lo;
  logic [2:0] level, press, rel, rpt;
  logic [2:0] level_lo, press_lo, rel_lo, rpt_lo;
  logic       tick, tick_lo;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int press_cnt[3], rel_cnt[3], rpt_cnt[3];
  int clash = 0, wide = 0, rpt_lo_cnt = 0;
  int lo_press_ev = 0, lo_rel_ev = 0;
  int rpt_times[$];
  logic [2:0] prev_press = '0, prev_rel = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_debounce_multi #(.N_KEYS(3), .SAMPLE_DIV(4), .STABLE_SAMPLES(3), .PRESS_LEVEL(1'b1),
                       .REPEAT_DELAY(5), .REPEAT_PERIOD(2)) dut (
    .Clk_50mhz(clk), .Rst_n(Rst_n), .btn_in(btn), .key_level(level), .key_press(press),
    .key_release(rel), .key_repeat(rpt), .sample_tick(tick));

  key_debounce_multi #(.N_KEYS(3), .SAMPLE_DIV(4), .STABLE_SAMPLES(3), .PRESS_LEVEL(1'b0),
                       .REPEAT_DELAY(5), .REPEAT_PERIOD(2)) dut_lo (
    .Clk_50mhz(clk), .Rst_n(Rst_n), .btn_in(btn_lo), .key_level(level_lo), .key_press(press_lo),
    .key_release(rel_lo), .key_repeat(rpt_lo), .sample_tick(tick_lo));

  // Event monitor: counts pulses and protocol violations, sampled on the falling edge.
  always @(negedge clk) begin
    if (Rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (press[i]) press_cnt[i]++;
        if (rel[i]) rel_cnt[i]++;
        if (rpt[i]) rpt_cnt[i]++;
        if (press[i] && rel[i]) clash++;
        if (rpt[i] && (rel[i] || press[i])) clash++;
        if ((press[i] && prev_press[i]) || (rel[i] && prev_rel[i])) wide++;
      end
      if (rpt[0]) rpt_times.push_back(cyc);
      if (rpt_lo != 3'b000) rpt_lo_cnt++;
      if (press_lo != 3'b000) lo_press_ev++;
      if (rel_lo != 3'b000) lo_rel_ev++;
    end
    prev_press = press;
    prev_rel   = rel;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    int last_tick;
    Rst_n = 1'b0; btn = 3'b000; btn_lo = 3'b111;
    step(5);
    n_chk++;
    if ({level, press, rel, rpt, tick, level_lo, press_lo, rel_lo, rpt_lo, tick_lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {level, press, rel, rpt, tick, level_lo, press_lo, rel_lo, rpt_lo, tick_lo});
    end
    Rst_n = 1'b1;
    last_tick = -1;
    for (int k = 0; k < 100; k++) begin
      step(1);
      n_chk++;
      if ({level, press, rel, rpt, level_lo, press_lo, rel_lo, rpt_lo} !== '0) begin
        n_fail++;
        $display("FAIL idle_outputs cyc %0d: got %b, want zero", cyc,
                 {level, press, rel, rpt, level_lo, press_lo, rel_lo, rpt_lo});
      end
      if (tick) begin
        if (last_tick >= 0) begin
          n_chk++;
          if (cyc - last_tick !== 4) begin
            n_fail++;
            $display("FAIL tick_period: got %0d, want 4", cyc - last_tick);
          end
        end
        last_tick = cyc;
      end
    end
  endtask

  task automatic test_clean_press;
    int c0, p0, r0, lat;
    bit seen;
    p0 = press_cnt[0]; r0 = rel_cnt[0];
    c0 = cyc; btn[0] = 1'b1;
    seen = 0; lat = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1);
      if (press[0]) begin seen = 1; lat = cyc - c0; end
    end
    n_chk++;
    if (!seen || lat < 11 || lat > 15) begin
      n_fail++;
      $display("FAIL press_latency: got %0d cycles (seen=%0d), want 11..15", lat, seen);
    end
    n_chk++;
    if (level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL press_level: got %b, want 1", level[0]);
    end
    step(40);
    n_chk++;
    if (press_cnt[0] - p0 !== 1 || level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL press_count: got %0d presses level %b, want 1 and 1", press_cnt[0] - p0, level[0]);
    end
    btn[0] = 1'b0;
    step(40);
    n_chk++;
    if (rel_cnt[0] - r0 !== 1 || press_cnt[0] - p0 !== 1 || level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL release_count: got rel %0d press %0d level %b, want 1 1 0",
               rel_cnt[0] - r0, press_cnt[0] - p0, level[0]);
    end
  endtask

  task automatic test_glitch;
    int p0, r0;
    p0 = press_cnt[1]; r0 = rel_cnt[1];
    btn[1] = 1'b1;
    step(7);
    btn[1] = 1'b0;
    step(40);
    n_chk++;
    if (press_cnt[1] !== p0 || rel_cnt[1] !== r0 || level[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch: got press %0d rel %0d level %b, want 0 0 0",
               press_cnt[1] - p0, rel_cnt[1] - r0, level[1]);
    end
  endtask

  task automatic test_bounce;
    int p0, r0;
    p0 = press_cnt[2]; r0 = rel_cnt[2];
    for (int k = 0; k < 10; k++) begin
      btn[2] = ~btn[2];
      step(3);
    end
    btn[2] = 1'b1;
    step(40);
    n_chk++;
    if (press_cnt[2] - p0 !== 1 || level[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_press: got %0d presses level %b, want 1 and 1", press_cnt[2] - p0, level[2]);
    end
    n_chk++;
    if (rel_cnt[2] !== r0) begin
      n_fail++;
      $display("FAIL bounce_release: got %0d releases, want 0", rel_cnt[2] - r0);
    end
    btn[2] = 1'b0;
    step(40);
  endtask

  task automatic test_active_low;
    int p0, r0;
    bit seen;
    logic [2:0] vec;
    p0 = lo_press_ev; r0 = lo_rel_ev;
    btn_lo = 3'b000;
    seen = 0; vec = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1);
      if (press_lo != 3'b000) begin seen = 1; vec = press_lo; end
    end
    n_chk++;
    if (vec !== 3'b111) begin
      n_fail++;
      $display("FAIL lo_press_vec: got %b, want 111", vec);
    end
    step(40);
    n_chk++;
    if (lo_press_ev - p0 !== 1 || level_lo !== 3'b111) begin
      n_fail++;
      $display("FAIL lo_press_once: got %0d events level %b, want 1 and 111", lo_press_ev - p0, level_lo);
    end
    btn_lo = 3'b111;
    seen = 0; vec = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1);
      if (rel_lo != 3'b000) begin seen = 1; vec = rel_lo; end
    end
    n_chk++;
    if (vec !== 3'b111) begin
      n_fail++;
      $display("FAIL lo_release_vec: got %b, want 111", vec);
    end
    step(40);
    n_chk++;
    if (lo_rel_ev - r0 !== 1 || level_lo !== 3'b000) begin
      n_fail++;
      $display("FAIL lo_release_once: got %0d events level %b, want 1 and 000", lo_rel_ev - r0, level_lo);
    end
  endtask

  task automatic test_repeat;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    int pc, n0, nrel;
    bit seen;
    rpt_times.delete();
    btn[0] = 1'b1;
    seen = 0; pc = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1);
      if (press[0]) begin seen = 1; pc = cyc; end
    end
    step(160);
    n_chk++;
    if (rpt_times.size() < 2 || rpt_times[0] - pc !== 20) begin
      n_fail++;
      $display("FAIL repeat_first: got %0d repeats, first at +%0d, want first at +20",
               rpt_times.size(), (rpt_times.size() > 0) ? rpt_times[0] - pc : -1);
    end else begin
      n_chk++;
      if (rpt_times[1] - rpt_times[0] !== 8) begin
        n_fail++;
        $display("FAIL repeat_period: got %0d cycles, want 8", rpt_times[1] - rpt_times[0]);
      end
    end
    btn[0] = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1);
      if (rel[0]) seen = 1;
    end
    nrel = rpt_cnt[0];
    n0 = seen;
    step(40);
    n_chk++;
    if (n0 !== 1 || rpt_cnt[0] !== nrel) begin
      n_fail++;
      $display("FAIL repeat_stop: got release %0d extra repeats %0d, want 1 and 0", n0, rpt_cnt[0] - nrel);
    end
`else
    btn[0] = 1'b1;
    step(120);
    btn[0] = 1'b0;
    step(40);
    n_chk++;
    if (rpt_cnt[0] + rpt_cnt[1] + rpt_cnt[2] + rpt_lo_cnt !== 0) begin
      n_fail++;
      $display("FAIL repeat_off: got %0d repeat pulses, want 0",
               rpt_cnt[0] + rpt_cnt[1] + rpt_cnt[2] + rpt_lo_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_debounce;
    int p0, q0;
    p0 = press_cnt[1]; q0 = lo_press_ev;
    btn[1] = 1'b1;
    step(8);
    btn[1] = 1'b0;
    Rst_n = 1'b0;
    step(3);
    Rst_n = 1'b1;
    step(40);
    n_chk++;
    if (press_cnt[1] !== p0 || level[1] !== 1'b0 || lo_press_ev !== q0) begin
      n_fail++;
      $display("FAIL reset_mid_debounce: got press %0d lo %0d level %b, want 0 0 0",
               press_cnt[1] - p0, lo_press_ev - q0, level[1]);
    end
  endtask

  task automatic test_exclusive;
    n_chk++;
    if (clash !== 0 || wide !== 0) begin
      n_fail++;
      $display("FAIL pulse_protocol: got %0d overlaps %0d wide pulses, want 0 0", clash, wide);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; rpt_cnt[i] = 0; end
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_active_low();
    test_repeat();
    test_reset_mid_debounce();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
